ysyx_23060061_dmem_resp: RTL



---
 rtl/ysyx_23060061_dmem_resp_if.sv | 28 ++
 rtl/ysyx_23060061_dmem_resp.sv | 119 +++++++++++
 2 files changed

// File: rtl/ysyx_23060061_dmem_resp_if.sv
// Request/response bus between the load/store path and the data memory.
// master = initiator (core), slave = responder (memory).
interface ysyx_23060061_dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wen,
        output req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid,
        input  resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen,
        input  req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid,
        output resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_23060061_dmem_resp.sv
// Multi-cycle data-memory responder, one outstanding transaction.
// Define YSYX_23060061_DMEM_RAND_DELAY_EN to add LFSR wait jitter.
module ysyx_23060061_dmem_resp #(
    parameter logic [31:0] ADDR_BASE  = 32'h80000000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2
) (
    input logic clk,
    input logic rst,
    ysyx_23060061_dmem_resp_if.slave bus
);

    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam int          CW       = $clog2(LATENCY + 4) + 1;
    localparam logic [32:0] MEMBYTES = 33'(4) << DEPTH_LOG2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] waitCyc;
    logic [31:0]   addrQ;
    logic [31:0]   wdataQ;
    logic [3:0]    wmaskQ;
    logic          wenQ;
    logic [31:0]   rdataQ;
    logic          errQ;

    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  commit;
    logic [31:0]           off;
    logic                  offErr;
    logic [DEPTH_LOG2-1:0] idx;

    assign bus.req_ready  = (state == IDLE) && rst;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdataQ;
    assign bus.resp_err   = errQ;

    assign accept = bus.req_valid && bus.req_ready;
    assign commit = (state == BUSY) && (cnt == '0);
    assign off    = addrQ - ADDR_BASE;
    assign offErr = {1'b0, off} >= MEMBYTES;
    assign idx    = off[DEPTH_LOG2+1:2];

`ifdef YSYX_23060061_DMEM_RAND_DELAY_EN
    logic [3:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 4'b1001;
        end else if (accept) begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    assign waitCyc = CW'(LATENCY) + CW'(lfsr[1:0]);
`else
    assign waitCyc = CW'(LATENCY);
`endif

    // BUSY lasts waitCyc+1 cycles; the last one is the commit edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addrQ  <= '0;
            wdataQ <= '0;
            wmaskQ <= '0;
            wenQ   <= 1'b0;
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        addrQ  <= bus.req_addr;
                        wenQ   <= bus.req_wen;
                        wdataQ <= bus.req_wdata;
                        wmaskQ <= bus.req_wmask;
                        cnt    <= waitCyc;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        errQ   <= offErr;
                        rdataQ <= (!wenQ && !offErr) ? mem[idx] : '0;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (commit && wenQ && !offErr) begin
            for (int b = 0; b < 4; b++) begin
                if (wmaskQ[b]) begin
                    mem[idx][8*b +: 8] <= wdataQ[8*b +: 8];
                end
            end
        end
    end

endmodule
